// File: rtl/mem_wb_stage.sv
// mem_wb_stage -- MEM/WB pipeline register with retire counter and halt FSM.
//
// The W stage latches the instruction leaving MEM. It can be held (StallW)
// or bubbled (FlushW). Every valid non-halt instruction that loads bumps a
// saturating retire counter. A halt marker moves the block from RUN to DRAIN.
// DRAIN lasts DRAIN_CYCLES edges and then enters HALTED, which is sticky until
// reset. DumpReq pulses for the first HALTED cycle. While DRAIN or HALTED,
// incoming instructions are dropped as bubbles.
//
// Optional feature macro: SUBWORD_LOAD_EN.
//   defined   : LoadTypeM is registered and load data is byte/half extracted
//               from ReadDataW at ALUOutW[1:0], then sign/zero extended.
//   undefined : LoadTypeM is ignored and load data is ReadDataW unchanged.
module mem_wb_stage #(
  parameter int unsigned DRAIN_CYCLES = 4   // legal range 1..15
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        StallW,
  input  logic        FlushW,
  input  logic        RegWriteM,
  input  logic        MemtoRegM,
  input  logic        HaltM,
  input  logic [4:0]  WriteRegM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] ReadDataM,
  input  logic [1:0]  LoadTypeM,
  output logic        RegWriteW,
  output logic [4:0]  WriteRegW,
  output logic [31:0] ResultW,
  output logic        ValidW,
  output logic [31:0] RetiredCount,
  output logic        Halted,
  output logic        DumpReq
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_DRAIN  = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  // Drain counter holds 0..DRAIN_CYCLES-1. The last value triggers HALTED.
  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

  state_t      state_q;
  logic [3:0]  drain_cnt_q;
  logic        dump_q;

  logic        valid_q;
  logic        regwrite_q;
  logic        memtoreg_q;
  logic [4:0]  writereg_q;
  logic [31:0] aluout_q;
  logic [31:0] readdata_q;
  logic [31:0] retired_q;
  logic [31:0] retired_d;
  logic [31:0] load_data;

  // An edge "loads" only in RUN with neither flush nor stall. The FSM and the
  // counter both key off this, so a stalled or flushed halt marker is inert.
  logic load_en;
  logic bubble_en;

  assign load_en   = (state_q == S_RUN) && !FlushW && !StallW;
  assign bubble_en = FlushW || (state_q != S_RUN);

  // W-stage pipeline registers: reset > flush > not-RUN bubble > stall > load.
  always_ff @(posedge CLK) begin
    if (reset || bubble_en) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      writereg_q <= 5'd0;
      aluout_q   <= 32'd0;
      readdata_q <= 32'd0;
    end else if (!StallW) begin
      // The halt marker still occupies W as a valid slot. It never writes
      // the register file.
      valid_q    <= 1'b1;
      regwrite_q <= RegWriteM && !HaltM;
      memtoreg_q <= MemtoRegM;
      writereg_q <= WriteRegM;
      aluout_q   <= ALUOutM;
      readdata_q <= ReadDataM;
    end
  end

  // Saturating retire count, next-state.
  always_comb begin
    retired_d = retired_q;
    if (load_en && !HaltM && (retired_q != 32'hFFFF_FFFF))
      retired_d = retired_q + 32'd1;
  end

  // Retire counter register.
  always_ff @(posedge CLK) begin
    if (reset) retired_q <= 32'd0;
    else       retired_q <= retired_d;
  end

  // Halt FSM: RUN -> DRAIN on halt load, DRAIN -> HALTED after the drain window.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q     <= S_RUN;
      drain_cnt_q <= 4'd0;
      dump_q      <= 1'b0;
    end else begin
      dump_q <= 1'b0;
      unique case (state_q)
        S_RUN: begin
          drain_cnt_q <= 4'd0;
          if (load_en && HaltM) state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          if (drain_cnt_q == DRAIN_LAST) begin
            state_q <= S_HALTED;
            dump_q  <= 1'b1;
          end else begin
            drain_cnt_q <= drain_cnt_q + 4'd1;
          end
        end
        S_HALTED: state_q <= S_HALTED;
        default: begin
          state_q     <= S_RUN;
          drain_cnt_q <= 4'd0;
        end
      endcase
    end
  end

`ifdef SUBWORD_LOAD_EN
  logic [1:0]  loadtype_q;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Load type follows the same hold/bubble rules as the other W fields.
  always_ff @(posedge CLK) begin
    if (reset || bubble_en) loadtype_q <= 2'b00;
    else if (!StallW)       loadtype_q <= LoadTypeM;
  end

  // Select the addressed byte and half, then extend according to load type.
  always_comb begin
    ld_byte = readdata_q[7:0];
    unique case (aluout_q[1:0])
      2'd0: ld_byte = readdata_q[7:0];
      2'd1: ld_byte = readdata_q[15:8];
      2'd2: ld_byte = readdata_q[23:16];
      2'd3: ld_byte = readdata_q[31:24];
      default: ld_byte = readdata_q[7:0];
    endcase
    ld_half = aluout_q[1] ? readdata_q[31:16] : readdata_q[15:0];
    unique case (loadtype_q)
      2'b00: load_data = readdata_q;
      2'b01: load_data = {{24{ld_byte[7]}}, ld_byte};
      2'b10: load_data = {{16{ld_half[15]}}, ld_half};
      2'b11: load_data = {24'd0, ld_byte};
      default: load_data = readdata_q;
    endcase
  end
`else
  // Word-only loads: the load type is not used in this build.
  logic unused_loadtype;
  assign unused_loadtype = ^LoadTypeM;
  assign load_data       = readdata_q;
`endif

  assign RegWriteW    = regwrite_q && valid_q;
  assign WriteRegW    = writereg_q;
  assign ResultW      = memtoreg_q ? load_data : aluout_q;
  assign ValidW       = valid_q;
  assign RetiredCount = retired_q;
  assign Halted       = (state_q == S_HALTED);
  assign DumpReq      = dump_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Testbench for mem_wb_stage. It runs directed scenarios and randomized
// traffic, and compares every cycle against a transaction-level model.
module tb_mem_wb_stage;

  localparam int DC = 4;

  logic        CLK = 1'b0;
  logic        reset, StallW, FlushW, RegWriteM, MemtoRegM, HaltM;
  logic [4:0]  WriteRegM;
  logic [31:0] ALUOutM, ReadDataM;
  logic [1:0]  LoadTypeM;
  logic        RegWriteW, ValidW, Halted, DumpReq;
  logic [4:0]  WriteRegW;
  logic [31:0] ResultW, RetiredCount;

  int checks = 0;
  int errors = 0;

  // Model of the W slot contents, plus retired count and halt age.
  logic        m_valid, m_rw, m_m2r;
  logic [4:0]  m_wr;
  logic [31:0] m_alu, m_rd, m_cnt;
  logic [1:0]  m_lt;
  int          m_hs;   // edges since the halt marker loaded; -1 = no halt seen

  mem_wb_stage #(.DRAIN_CYCLES(DC)) dut (
    .CLK(CLK), .reset(reset), .StallW(StallW), .FlushW(FlushW),
    .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .HaltM(HaltM),
    .WriteRegM(WriteRegM), .ALUOutM(ALUOutM), .ReadDataM(ReadDataM),
    .LoadTypeM(LoadTypeM), .RegWriteW(RegWriteW), .WriteRegW(WriteRegW),
    .ResultW(ResultW), .ValidW(ValidW), .RetiredCount(RetiredCount),
    .Halted(Halted), .DumpReq(DumpReq)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] exp_load(input logic [31:0] rd, input logic [31:0] alu,
                                           input logic [1:0] lt);
`ifdef SUBWORD_LOAD_EN
    logic [31:0] b, h;
    b = (rd >> (8 * (alu % 4))) & 32'hFF;
    h = (rd >> (16 * ((alu / 2) % 2))) & 32'hFFFF;
    case (lt)
      2'd1: return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
      2'd2: return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
      2'd3: return b;
      default: return rd;
    endcase
`else
    return rd;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("ValidW", 32'(ValidW), 32'(m_valid));
    chk("RegWriteW", 32'(RegWriteW), 32'(m_rw & m_valid));
    chk("WriteRegW", 32'(WriteRegW), 32'(m_wr));
    chk("ResultW", ResultW, m_m2r ? exp_load(m_rd, m_alu, m_lt) : m_alu);
    chk("RetiredCount", RetiredCount, m_cnt);
    chk("Halted", 32'(Halted), 32'(m_hs >= DC));
    chk("DumpReq", 32'(DumpReq), 32'(m_hs == DC));
  endtask

  task automatic model_bubble();
    m_valid = 0; m_rw = 0; m_m2r = 0; m_wr = 0; m_alu = 0; m_rd = 0; m_lt = 0;
  endtask

  // Apply one cycle of inputs. The model advances at the edge and the DUT is
  // checked on the following falling edge.
  task automatic step(input logic rst, input logic st, input logic fl, input logic rw,
                      input logic m2r, input logic h, input logic [4:0] wr,
                      input logic [31:0] alu, input logic [31:0] rd, input logic [1:0] lt);
    bit running;
    reset = rst; StallW = st; FlushW = fl; RegWriteM = rw; MemtoRegM = m2r;
    HaltM = h; WriteRegM = wr; ALUOutM = alu; ReadDataM = rd; LoadTypeM = lt;
    @(posedge CLK);
    if (rst) begin
      model_bubble(); m_cnt = 0; m_hs = -1;
    end else begin
      running = (m_hs < 0);
      if (m_hs >= 0 && m_hs < 1000) m_hs++;
      if (fl || !running) model_bubble();
      else if (!st) begin
        m_valid = 1; m_rw = rw & ~h; m_m2r = m2r; m_wr = wr;
        m_alu = alu; m_rd = rd; m_lt = lt;
        if (h) m_hs = 0;
        else if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
      end
    end
    @(negedge CLK);
    check_all();
  endtask

  task automatic rand_step(input int halt_pct, input int rst_pct);
    step(($urandom_range(99) < rst_pct), ($urandom_range(3) == 0), ($urandom_range(7) == 0),
         1'($urandom), 1'($urandom), ($urandom_range(99) < halt_pct),
         5'($urandom), $urandom, $urandom, 2'($urandom));
  endtask

  initial begin
    reset = 1; StallW = 0; FlushW = 0; RegWriteM = 0; MemtoRegM = 0; HaltM = 0;
    WriteRegM = 0; ALUOutM = 0; ReadDataM = 0; LoadTypeM = 0;
    model_bubble(); m_cnt = 0; m_hs = -1;
    @(negedge CLK);

    // Reset state.
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 1, 1, 1, 5'd9, 32'h55, 32'h66, 0);
    chk("rst_valid", 32'(ValidW), 32'd0);
    chk("rst_count", RetiredCount, 32'd0);
    chk("rst_halted", 32'(Halted), 32'd0);

    // Simple ALU write.
    step(0, 0, 0, 1, 0, 0, 5'd5, 32'h1234, 32'h0, 0);
    chk("alu_rw", 32'(RegWriteW), 32'd1);
    chk("alu_wr", 32'(WriteRegW), 32'd5);
    chk("alu_res", ResultW, 32'h1234);
    chk("alu_cnt", RetiredCount, 32'd1);

    // A load held by stall for two cycles, then released.
    step(0, 1, 0, 1, 1, 0, 5'd7, 32'h0, 32'hDEADBEEF, 0);
    chk("stall1_res", ResultW, 32'h1234);
    step(0, 1, 0, 1, 1, 0, 5'd7, 32'h0, 32'hDEADBEEF, 0);
    chk("stall2_res", ResultW, 32'h1234);
    step(0, 0, 0, 1, 1, 0, 5'd7, 32'h0, 32'hDEADBEEF, 0);
    chk("load_res", ResultW, 32'hDEADBEEF);
    chk("load_cnt", RetiredCount, 32'd2);

    // Flush wins over stall.
    step(0, 1, 1, 1, 0, 0, 5'd3, 32'h99, 32'h0, 0);
    chk("flush_valid", 32'(ValidW), 32'd0);
    chk("flush_rw", 32'(RegWriteW), 32'd0);
    chk("flush_cnt", RetiredCount, 32'd2);

    // A halt under stall or flush does not trigger; a loaded halt then drains.
    step(0, 1, 0, 1, 0, 1, 5'd1, 32'hFFFFFFFF, 0, 0);
    step(0, 0, 1, 1, 0, 1, 5'd1, 32'hFFFFFFFF, 0, 0);
    chk("halt_flushed", 32'(Halted), 32'd0);
    step(0, 0, 0, 1, 0, 1, 5'd1, 32'hFFFFFFFF, 0, 0);
    chk("halt_rw", 32'(RegWriteW), 32'd0);
    for (int i = 0; i < DC; i++) step(0, 0, 0, 1, 0, 0, 5'd2, 32'h10 + i, 0, 0);
    chk("drain_halted", 32'(Halted), 32'd1);
    chk("drain_dump", 32'(DumpReq), 32'd1);
    chk("drain_cnt", RetiredCount, 32'd2);
    step(0, 0, 0, 1, 0, 0, 5'd2, 32'h20, 0, 0);
    chk("dump_pulse", 32'(DumpReq), 32'd0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_clr_halt", 32'(Halted), 32'd0);
    chk("rst_clr_dump", 32'(DumpReq), 32'd0);

`ifdef SUBWORD_LOAD_EN
    step(0, 0, 0, 1, 1, 0, 5'd4, 32'h2, 32'h80FF7F01, 2'b01);
    chk("lb_signed", ResultW, 32'hFFFFFFFF);
    step(0, 0, 0, 1, 1, 0, 5'd4, 32'h2, 32'h80FF7F01, 2'b11);
    chk("lbu", ResultW, 32'h000000FF);
    step(0, 0, 0, 1, 1, 0, 5'd4, 32'h2, 32'h80FF7F01, 2'b10);
    chk("lh_signed", ResultW, 32'hFFFF80FF);
`endif

    // Randomized traffic with occasional halts and resets.
    for (int i = 0; i < 600; i++) rand_step(3, 2);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 300; i++) rand_step(0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
